// File: rtl/sram_1rw1r_ctrl.sv
// Controller for a 1RW+1R SRAM macro: clears the array after reset, then
// arbitrates a writer and a reader on port 0 and serves a second reader on port 1.
module sram_1rw1r_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_WMASKS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // write requester W (port 0)
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [NUM_WMASKS-1:0] w_mask,
  // read requester R0 (port 0)
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  // read requester R1 (port 1)
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  // SRAM macro pins
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0,
  output logic                  csb1,
  output logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] dout1,
  output logic                  init_done
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  last_w;
  logic                  run;
  logic                  w_fire, r0_fire, r1_fire;
  logic                  p0_pend, p1_pend;

  assign run = (state == S_RUN);

  // Contested port 0 goes to whoever did not win last; R1 stalls on a same-address write.
  always_comb begin
    w_ready  = run && (!r0_valid || !last_w);
    r0_ready = run && (!w_valid || last_w);
    w_fire   = w_valid && w_ready;
    r0_fire  = r0_valid && r0_ready;
    r1_ready = run && !(w_fire && (r1_addr == w_addr));
    r1_fire  = r1_valid && r1_ready;
  end

  always_comb begin
    csb0   = 1'b1;
    web0   = 1'b1;
    wmask0 = '0;
    addr0  = '0;
    din0   = '0;
    if (rst_n) begin
      if (state == S_INIT) begin
        csb0   = 1'b0;
        web0   = 1'b0;
        wmask0 = '1;
        addr0  = init_addr;
      end else if (w_fire) begin
        csb0   = 1'b0;
        web0   = 1'b0;
        wmask0 = w_mask;
        addr0  = w_addr;
        din0   = w_data;
      end else if (r0_fire) begin
        csb0   = 1'b0;
        addr0  = r0_addr;
      end
    end
  end

  always_comb begin
    csb1  = !r1_fire;
    addr1 = r1_fire ? r1_addr : '0;
  end

  always_comb begin
    state_nxt = state;
    if ((state == S_INIT) && (init_addr == '1)) state_nxt = S_RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      init_addr <= '0;
      init_done <= 1'b0;
      last_w    <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_done <= (state_nxt == S_RUN);
      if (state == S_INIT) init_addr <= init_addr + ADDR_WIDTH'(1);
      if (w_fire)       last_w <= 1'b1;
      else if (r0_fire) last_w <= 1'b0;
    end
  end

  // Two-stage read pipeline: macro access at the accept edge, capture of dout one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_pend   <= 1'b0;
      p1_pend   <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
    end else begin
      p0_pend   <= r0_fire;
      p1_pend   <= r1_fire;
      r0_rvalid <= p0_pend;
      r1_rvalid <= p1_pend;
      if (p0_pend) r0_rdata <= dout0;
      if (p1_pend) r1_rdata <= dout1;
    end
  end

endmodule

// File: doc/sram_1rw1r_ctrl.md
SRAM_1RW1R_CTRL -- requirements
Module: sram_1rw1r_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, SRAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, SRAM address width; depth = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter NUM_WMASKS, default 4, byte-lane write-mask width (DATA_WIDTH/8).
REQ-004 SHALL have: clk  in  1  single clock, also wired to SRAM clk0/clk1.
REQ-005 SHALL have: rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have: w_valid in 1, w_ready out 1, w_addr in ADDR_WIDTH, w_data in DATA_WIDTH, w_mask in NUM_WMASKS  -- write requester W, port 0.
REQ-007 SHALL have: r0_valid in 1, r0_ready out 1, r0_addr in ADDR_WIDTH, r0_rvalid out 1, r0_rdata out DATA_WIDTH  -- read requester R0, port 0.
REQ-008 SHALL have: r1_valid in 1, r1_ready out 1, r1_addr in ADDR_WIDTH, r1_rvalid out 1, r1_rdata out DATA_WIDTH  -- read requester R1, port 1.
REQ-009 SHALL have SRAM pins: csb0, web0 out 1; wmask0 out NUM_WMASKS; addr0 out ADDR_WIDTH; din0 out DATA_WIDTH; dout0 in DATA_WIDTH; csb1 out 1; addr1 out ADDR_WIDTH; dout1 in DATA_WIDTH (csb/web active low).
REQ-010 SHALL have: init_done  out  1  high once memory clear completes.

Function
REQ-011 SHALL implement FSM INIT -> RUN; INIT entered on reset, RUN is terminal until next reset.
REQ-012 In INIT SHALL write all-zero, wmask all-ones, to addresses 0..depth-1 ascending, one per cycle, via port 0; all *_ready = 0.
REQ-013 After the write to depth-1 SHALL enter RUN next cycle and set init_done = 1 (registered).
REQ-014 Handshake: transfer occurs when valid && ready in same cycle; ready SHALL not depend on the same requester's addr/data.
REQ-015 In RUN port 0 SHALL be granted to exactly one of W, R0 per cycle; if only one valid, it wins.
REQ-016 If both W and R0 valid, SHALL grant round-robin using a 1-bit last-grant register; after reset first contested grant goes to W.
REQ-017 Last-grant register SHALL update only on contested or uncontested accepted transfers.
REQ-018 Granted W: csb0=0, web0=0, addr0=w_addr, din0=w_data, wmask0=w_mask, combinationally in the accept cycle.
REQ-019 Granted R0: csb0=0, web0=1, addr0=r0_addr, wmask0=0; no grant: csb0=1, web0=1.
REQ-020 R1 accepted: csb1=0, addr1=r1_addr; otherwise csb1=1.
REQ-021 Collision: if W accepted and r1_valid with r1_addr == w_addr same cycle, r1_ready SHALL be 0 that cycle (R1 stalls, retries next cycle).
REQ-022 Read latency: request accepted in cycle N SHALL give rvalid=1 for exactly one cycle N+2 with rdata = SRAM dout registered at end of N+1.
REQ-023 Reads SHALL be pipelined: one accept per cycle per port, responses in order; no response backpressure.
REQ-024 A write accepted in cycle N SHALL be visible to any read accepted in cycle N+1 or later on either port.
REQ-025 Reads with zero pending (rvalid=0) SHALL hold rdata at last value.

Reset
REQ-026 rst_n low SHALL immediately force: csb0=1, web0=1, csb1=1, wmask0=0, all *_ready=0, r0_rvalid=r1_rvalid=0, init_done=0, last-grant=R0 (so W wins first), init address=0, FSM=INIT.
REQ-027 Reset asserted mid-INIT or mid-RUN SHALL discard in-flight reads (no rvalid after release) and restart INIT from address 0.
REQ-028 rdata registers SHALL reset to 0.

Verification
REQ-029 Release reset -> exactly 512 write cycles addr 0..511, data 0; init_done=1 in cycle 513; no ready before.
REQ-030 RUN: W writes 0xDEADBEEF mask 4'b0101 to addr 5 over 0xFFFFFFFF, then R0 reads addr 5 -> r0_rvalid two cycles after accept, r0_rdata=0xFFADFFEF.
REQ-031 W and R0 both valid continuously for 6 cycles -> grants W,R0,W,R0,W,R0; each accepted read returns rvalid exactly 2 cycles later.
REQ-032 Same cycle W addr 0x10 data 0x12345678 and R1 addr 0x10 -> r1_ready=0; R1 accepted next cycle, r1_rdata=0x12345678.
REQ-033 R1 issues back-to-back reads addr 1,2,3 -> r1_rvalid high 3 consecutive cycles, data in request order.
REQ-034 Assert rst_n low with 2 reads in flight -> all outputs at reset values immediately; no rvalid after release; INIT restarts at address 0.
